// File: rtl/microstep_sequencer_pkg.sv
// Shared definitions for the microstep sequencer slice.
//   STEP_W  : microstep counter width (fixed at 3)
//   state_t : sequencer FSM states, encoded as published on the state port
package microstep_sequencer_pkg;

  localparam int STEP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_IRQ  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_3bit.sv
// Microstep counter of the PDUA control unit.
// Updates on the falling edge, like the rest of the datapath.
//   clk   : clock (falling edge active)
//   rst   : asynchronous active-high reset, clears count
//   ena   : add a to count
//   sclr  : synchronous clear (wins over ena)
//   a     : increment amount
//   count : current count
module counter_3bit
  import microstep_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              sclr,
  input  logic [STEP_W-1:0] a,
  output logic [STEP_W-1:0] count
);

  logic [STEP_W-1:0] count_r;

  // Count register: clear, add, or hold.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 3'd0;
    end else if (sclr) begin
      count_r <= 3'd0;
    end else if (ena) begin
      count_r <= count_r + a;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/microstep_sequencer.sv
// Control FSM sequencing the 3-bit microstep counter. Steps through the
// microsteps of an instruction, waits out memory stalls, applies skip (+2)
// advances, and at the retire step hands off to IRQ service, the next
// instruction, or IDLE.
//   clk/rst    : falling-edge clock, async active-high reset
//   start      : begin instruction (IDLE, or at the retire edge)
//   opcode_len : microsteps in the instruction (0 means 1)
//   mem_step   : current microstep accesses memory
//   mem_rdy    : memory ready
//   skip       : advance by 2 instead of 1
//   irq        : interrupt request, looked at only on the retire edge
//   halt       : blocks start in IDLE
//   step       : current microstep (counter output)
//   state      : IDLE=0 RUN=1 WAIT=2 IRQ=3
//   busy       : RUN or WAIT
//   done       : one-cycle pulse after retire
//   irq_ack    : high for the single IRQ cycle
module microstep_sequencer
  import microstep_sequencer_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] opcode_len,
  input  logic              mem_step,
  input  logic              mem_rdy,
  input  logic              skip,
  input  logic              irq,
  input  logic              halt,
  output logic [STEP_W-1:0] step,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done,
  output logic              irq_ack
);

  state_t            state_r, state_nx_s;
  logic [STEP_W-1:0] len_r;
  logic              done_r, irq_ack_r, busy_r;

  logic              stall_s, last_s, load_len_s, done_nx_s;
  logic              ena_s, sclr_s;
  logic [STEP_W-1:0] a_s, inc_s, step_s;

  assign stall_s = mem_step & ~mem_rdy;
  assign inc_s   = skip ? 3'd2 : 3'd1;
  // 4-bit compare so step+inc cannot wrap before the comparison.
  assign last_s  = ({1'b0, step_s} + {1'b0, inc_s}) >= {1'b0, len_r};

  // Next-state and counter-control decode.
  always_comb begin
    state_nx_s = state_r;
    ena_s      = 1'b0;
    sclr_s     = 1'b0;
    a_s        = 3'd0;
    done_nx_s  = 1'b0;
    load_len_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sclr_s = 1'b1;
        if (start & ~halt) begin
          state_nx_s = ST_RUN;
          load_len_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN, ST_WAIT: begin
        if (stall_s) begin
          state_nx_s = ST_WAIT;
        end else if (!last_s) begin
          ena_s      = 1'b1;
          a_s        = inc_s;
          state_nx_s = ST_RUN;
        end else begin
          // Retire: irq outranks a chained start.
          sclr_s    = 1'b1;
          done_nx_s = 1'b1;
          if (irq) begin
            state_nx_s = ST_IRQ;
          end else if (start & ~halt) begin
            state_nx_s = ST_RUN;
            load_len_s = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
      end
      ST_IRQ: begin
        sclr_s     = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        sclr_s     = 1'b1;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, latched length and registered status outputs.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      len_r     <= 3'd1;
      done_r    <= 1'b0;
      irq_ack_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      if (load_len_s) begin
        len_r <= (opcode_len == 3'd0) ? 3'd1 : opcode_len;
      end else begin
        len_r <= len_r;
      end
      done_r    <= done_nx_s;
      irq_ack_r <= (state_nx_s == ST_IRQ);
      busy_r    <= (state_nx_s == ST_RUN) || (state_nx_s == ST_WAIT);
    end
  end

  counter_3bit u_counter (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena_s),
    .sclr  (sclr_s),
    .a     (a_s),
    .count (step_s)
  );

  assign step    = step_s;
  assign state   = state_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign irq_ack = irq_ack_r;

endmodule

// File: doc/microstep_sequencer.md
# microstep_sequencer

Control FSM that sequences the 3-bit microstep counter of the PDUA control unit. It steps through the microsteps of each instruction, inserts memory wait states, and applies skip (+2) advances. At instruction boundaries it hands off to interrupt service or to the next instruction. It drives the counter's `ena`, `sclr` and increment inputs and publishes the current microstep to the microcode ROM.

## Interface
Parameters:
- `STEP_W`, 3, microstep width; fixed, no other value supported.

Ports:
- `clk` in 1: clock; all state updates on the falling edge, same as the datapath.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin an instruction; sampled in IDLE, and at the retire edge in RUN/WAIT.
- `opcode_len` in 3: microsteps in the instruction; latched with `start`; 0 is treated as 1.
- `mem_step` in 1: current microstep accesses memory (from microcode ROM).
- `mem_rdy` in 1: memory ready.
- `skip` in 1: advance by 2 instead of 1; sampled on advance edges.
- `irq` in 1: interrupt request; sampled only at the retire edge.
- `halt` in 1: blocks `start` in IDLE.
- `step` out 3: current microstep (counter output).
- `state` out 2: IDLE=0, RUN=1, WAIT=2, IRQ=3.
- `busy` out 1: state is RUN or WAIT.
- `done` out 1: one-cycle pulse after an instruction retires.
- `irq_ack` out 1: high while in IRQ (exactly one cycle).

## Operation
- Internal register `len_q` (3 bit). On `start` it loads `opcode_len`, or 1 when `opcode_len`==0.
- Stall condition: `mem_step & ~mem_rdy`.
- Advance increment: `inc` = `skip` ? 2 : 1.
- Last-step test is a 4-bit compare: `{0,step} + inc >= {0,len_q}`. The counter's 3-bit wrap is never exercised.

State transitions:
- IDLE: counter held clear (`sclr`=1).
  - `start & ~halt` -> RUN, with `len_q` latched and `step`=0.
- RUN:
  - Stall -> WAIT, `step` held.
  - Not last step: `ena`=1, `a`=`inc`.
  - Last step (retire): `sclr`=1, `done` set. Next state is IRQ if `irq`; otherwise RUN if `start & ~halt` (relatch `len_q`); otherwise IDLE.
- WAIT:
  - Stall -> stay in WAIT.
  - Otherwise perform exactly the RUN advance/retire action. WAIT never costs an extra cycle beyond the stall.
- IRQ: `sclr`=1, `irq_ack`=1, then -> IDLE unconditionally.

Priorities and ignored inputs:
- At retire, `irq` has priority over `start`.
- `halt` is ignored in RUN/WAIT; the current instruction always completes.
- `irq` outside the retire edge is ignored; the interrupt source must hold it.
- `skip` during a stall is ignored.

Counter control:
- `sclr` and `ena` are never both asserted.
- `a` is 0 whenever `ena`=0.

## Timing
- Reset values: `state`=IDLE, `step`=0, `len_q`=1, `done`=0, `irq_ack`=0, `busy`=0.
- Reset mid-instruction aborts immediately. No `done` is issued.
- Instruction of length L, no stalls, no skips: L falling edges in RUN. `step` goes 0..L-1, then 0 with `done`=1 for the following cycle.
- Each cycle with the stall condition true adds exactly one cycle.
- Back-to-back: `start` at the retire edge gives zero idle cycles. The new instruction's `step`=0 cycle coincides with the `done` pulse of the previous instruction.
- `done` and `irq_ack` are registered and go high for one clock after the edge that sets them.

## Structure
- Shared package holds the state encodings (IDLE/RUN/WAIT/IRQ) and `STEP_W`.
- One sub-module: the existing `counter_3bit`, instantiated with `ena`/`sclr`/`a` driven combinationally from the FSM. Its `count` is `step`.
- FSM register, `len_q`, and the `done`/`irq_ack` flops sit in this module on the falling edge with async `rst`.

## Test plan
- `opcode_len`=3, `start` one cycle, no stalls -> `step` 0,1,2,0; `done` high one cycle; `state` RUN->IDLE; `busy` high 3 cycles.
- `opcode_len`=4, `mem_step`=1 at step 1 with `mem_rdy` low 2 cycles -> `step` 0,1,1,1,2,3,0; `state` WAIT for 2 cycles; total 6 busy cycles.
- `opcode_len`=5, `skip` at step 1 and at step 3 -> `step` 0,1,3,0; retire on step 3 since 3+2>=5; `done` pulses.
- `irq` and `start` both high at retire of a 2-step instruction -> IRQ one cycle with `irq_ack`=1, then IDLE; `start` ignored.
- Back-to-back: `start` held, `opcode_len`=0 then 2 -> 1-step then 2-step instruction, `step` 0,0,1,0; two `done` pulses.
- `rst` asserted at step 2 of a 5-step instruction -> immediate `step`=0, IDLE, no `done`. `halt`=1 with `start` in IDLE -> stays IDLE.
